// File: rtl/ms_timer_sched_if.sv
// Arm/cancel/expiry bundle for ms_timer_sched; arm_per exists only when
// MS_TIMER_SCHED_AUTO_RELOAD_EN is defined.
interface ms_timer_sched_if #(
   parameter int CH_W = 2,
   parameter int MS_W = 16
);
   localparam int NCH = 2**CH_W;

   logic            arm_vld;
   logic [CH_W-1:0] arm_ch;
   logic [MS_W-1:0] arm_ms;
   logic            arm_rdy;
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
   logic            arm_per;
`endif
   logic            cancel;
   logic [CH_W-1:0] cancel_ch;
   logic [NCH-1:0]  busy;
   logic            exp_vld;
   logic [CH_W-1:0] exp_ch;
   logic            exp_rdy;

`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
   modport master (output arm_vld, arm_ch, arm_ms, arm_per, cancel, cancel_ch, exp_rdy,
                   input  arm_rdy, busy, exp_vld, exp_ch);
   modport slave  (input  arm_vld, arm_ch, arm_ms, arm_per, cancel, cancel_ch, exp_rdy,
                   output arm_rdy, busy, exp_vld, exp_ch);
`else
   modport master (output arm_vld, arm_ch, arm_ms, cancel, cancel_ch, exp_rdy,
                   input  arm_rdy, busy, exp_vld, exp_ch);
   modport slave  (input  arm_vld, arm_ch, arm_ms, cancel, cancel_ch, exp_rdy,
                   output arm_rdy, busy, exp_vld, exp_ch);
`endif
endinterface

// File: rtl/ms_timer_sched.sv
// Multi-channel ms timeout scheduler with round-robin expiry port.
// Optional periodic reload: define MS_TIMER_SCHED_AUTO_RELOAD_EN.
module ms_timer_sched #(
   parameter int CH_W = 2,
   parameter int MS_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ms_tick,
   ms_timer_sched_if.slave bus
);
   localparam int NCH = 2**CH_W;
   localparam logic [MS_W-1:0] ONE = MS_W'(1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PEND = 2'd2} ch_st_e;

   ch_st_e          st_q  [NCH];
   ch_st_e          st_d  [NCH];
   logic [MS_W-1:0] cnt_q [NCH];
   logic [MS_W-1:0] cnt_d [NCH];
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
   logic [MS_W-1:0] rld_q [NCH];
   logic [MS_W-1:0] rld_d [NCH];
   logic [NCH-1:0]  per_q, per_d;
`endif
   logic            exp_vld_q, exp_vld_d;
   logic [CH_W-1:0] exp_ch_q, exp_ch_d;
   logic [CH_W-1:0] rr_q, rr_d;

   logic            arm_rdy, arm_fire, hs, found;
   logic [CH_W-1:0] idx;
   logic [NCH-1:0]  pres, armed, canc, pend_ok, busy;

   assign arm_rdy     = !(exp_vld_q && (exp_ch_q == bus.arm_ch));
   assign arm_fire    = bus.arm_vld && arm_rdy;
   assign hs          = exp_vld_q && bus.exp_rdy;
   assign bus.arm_rdy = arm_rdy;
   assign bus.busy    = busy;
   assign bus.exp_vld = exp_vld_q;
   assign bus.exp_ch  = exp_ch_q;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         pres[i]  = exp_vld_q && (exp_ch_q == CH_W'(i));
         armed[i] = arm_fire && (bus.arm_ch == CH_W'(i));
         canc[i]  = bus.cancel && (bus.cancel_ch == CH_W'(i)) && !pres[i];
         busy[i]  = (st_q[i] != S_IDLE);
      end
   end

   // Priority per channel: arm > handshake > cancel > tick.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
         rld_d[i] = rld_q[i];
         per_d[i] = per_q[i];
`endif
         if (armed[i]) begin
            st_d[i]  = (bus.arm_ms != '0) ? S_RUN : S_PEND;
            cnt_d[i] = bus.arm_ms;
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
            rld_d[i] = bus.arm_ms;
            per_d[i] = bus.arm_per && (bus.arm_ms != '0);
`endif
         end else if (hs && pres[i]) begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
            if (per_q[i] && (rld_q[i] != '0)) begin
               st_d[i]  = S_RUN;
               cnt_d[i] = rld_q[i];
            end
`endif
         end else if (canc[i]) begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
            per_d[i] = 1'b0;
`endif
         end else if ((st_q[i] == S_RUN) && ms_tick) begin
            if (cnt_q[i] == ONE) begin
               st_d[i]  = S_PEND;
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] - ONE;
            end
         end
         // A channel being re-armed or cancelled this cycle must not be granted.
         pend_ok[i] = (st_q[i] == S_PEND) && !armed[i] && !canc[i];
      end
   end

   always_comb begin
      exp_vld_d = exp_vld_q;
      exp_ch_d  = exp_ch_q;
      rr_d      = rr_q;
      found     = 1'b0;
      idx       = '0;
      if (hs) begin
         exp_vld_d = 1'b0;
      end else if (!exp_vld_q) begin
         // k = NCH wraps to rr_q itself, giving it lowest priority.
         for (int k = 1; k <= NCH; k++) begin
            idx = rr_q + CH_W'(k);
            if (!found && pend_ok[idx]) begin
               found     = 1'b1;
               exp_vld_d = 1'b1;
               exp_ch_d  = idx;
               rr_d      = idx;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i]  <= S_IDLE;
            cnt_q[i] <= '0;
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
            rld_q[i] <= '0;
`endif
         end
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
         per_q <= '0;
`endif
         exp_vld_q <= 1'b0;
         exp_ch_q  <= '0;
         rr_q      <= CH_W'(NCH - 1);
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
         rld_q     <= rld_d;
         per_q     <= per_d;
`endif
         exp_vld_q <= exp_vld_d;
         exp_ch_q  <= exp_ch_d;
         rr_q      <= rr_d;
      end
   end
endmodule

// File: tb/tb_ms_timer_sched.sv
// Scenario tasks plus a randomized run against a behavioural scheduler model.
module tb_ms_timer_sched;
   localparam int CH_W = 2;
   localparam int MS_W = 16;
   localparam int NCH  = 2**CH_W;

   logic clk, rst, ms_tick;
   int   checks = 0;
   int   errors = 0;

   ms_timer_sched_if #(.CH_W(CH_W), .MS_W(MS_W)) bus ();
   ms_timer_sched #(.CH_W(CH_W), .MS_W(MS_W)) dut (
      .clk(clk), .rst(rst), .ms_tick(ms_tick), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: per channel 0=idle 1=running 2=expired-waiting, plus remaining ms.
   int m_st [NCH];
   int m_rem [NCH];
   bit m_vld;
   int m_ch;
   int m_rr;

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      ms_tick = 0; bus.arm_vld = 0; bus.arm_ch = '0; bus.arm_ms = '0;
      bus.cancel = 0; bus.cancel_ch = '0; bus.exp_rdy = 0;
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
      bus.arm_per = 0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 0; cyc(); cyc(); rst = 1; cyc();
   endtask

   task automatic tick();
      ms_tick = 1; cyc(); ms_tick = 0;
   endtask

   task automatic arm(input int ch, input int ms);
      bus.arm_vld = 1; bus.arm_ch = CH_W'(ch); bus.arm_ms = MS_W'(ms);
      cyc(); bus.arm_vld = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0; #1;
      checks++; if (bus.exp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", bus.exp_vld); end
      checks++; if (bus.exp_ch !== '0) begin errors++; $display("FAIL reset_ch got %0d exp 0", bus.exp_ch); end
      checks++; if (bus.busy !== '0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.arm_rdy !== 1'b1) begin errors++; $display("FAIL reset_arm_rdy got %0b exp 1", bus.arm_rdy); end
      cyc(); rst = 1; cyc();
   endtask

   task automatic test_basic();
      do_reset();
      arm(1, 3);
      checks++; if (bus.busy !== 4'b0010) begin errors++; $display("FAIL basic_busy got %b exp 0010", bus.busy); end
      for (int k = 0; k < 3; k++) begin
         repeat (9) cyc();
         tick();
      end
      checks++; if (bus.exp_vld !== 1'b0) begin errors++; $display("FAIL basic_early got %0b exp 0", bus.exp_vld); end
      cyc();
      checks++; if (bus.exp_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got %0b exp 1", bus.exp_vld); end
      checks++; if (bus.exp_ch !== 2'd1) begin errors++; $display("FAIL basic_ch got %0d exp 1", bus.exp_ch); end
      bus.exp_rdy = 1; cyc(); bus.exp_rdy = 0;
      checks++; if (bus.exp_vld !== 1'b0) begin errors++; $display("FAIL basic_drop got %0b exp 0", bus.exp_vld); end
      checks++; if (bus.busy[1] !== 1'b0) begin errors++; $display("FAIL basic_busy_clr got %0b exp 0", bus.busy[1]); end
   endtask

   task automatic test_back_to_back();
      int ev [5] = '{0, 1, 0, 1, 0};
      int ec [5] = '{0, 2, 0, 3, 0};
      do_reset();
      arm(0, 2); arm(2, 2); arm(3, 2);
      tick(); cyc(); tick(); cyc();
      checks++; if (bus.exp_vld !== 1'b1 || bus.exp_ch !== 2'd0) begin
         errors++; $display("FAIL b2b_first got vld=%0b ch=%0d exp vld=1 ch=0", bus.exp_vld, bus.exp_ch); end
      for (int k = 0; k < 50; k++) begin
         cyc();
         checks++; if (bus.exp_vld !== 1'b1 || bus.exp_ch !== 2'd0) begin
            errors++; $display("FAIL b2b_stall cyc %0d got vld=%0b ch=%0d exp vld=1 ch=0", k, bus.exp_vld, bus.exp_ch); end
      end
      bus.exp_rdy = 1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         checks++; if (bus.exp_vld !== ev[k][0] || (ev[k] == 1 && bus.exp_ch !== 2'(ec[k]))) begin
            errors++; $display("FAIL b2b_seq step %0d got vld=%0b ch=%0d exp vld=%0d ch=%0d", k, bus.exp_vld, bus.exp_ch, ev[k], ec[k]); end
      end
      bus.exp_rdy = 0;
      checks++; if (bus.busy !== '0) begin errors++; $display("FAIL b2b_busy got %b exp 0", bus.busy); end
   endtask

   task automatic test_cancel();
      bit seen = 0;
      arm(2, 5);
      tick(); cyc(); tick();
      bus.cancel = 1; bus.cancel_ch = 2'd2; cyc(); bus.cancel = 0;
      checks++; if (bus.busy[2] !== 1'b0) begin errors++; $display("FAIL cancel_busy got %0b exp 0", bus.busy[2]); end
      for (int k = 0; k < 5; k++) begin
         tick(); cyc();
         if (bus.exp_vld !== 1'b0) seen = 1;
      end
      checks++; if (seen) begin errors++; $display("FAIL cancel_noevent got event exp none"); end
      arm(2, 0); cyc();
      checks++; if (bus.exp_vld !== 1'b1 || bus.exp_ch !== 2'd2) begin
         errors++; $display("FAIL cancel_zero got vld=%0b ch=%0d exp vld=1 ch=2", bus.exp_vld, bus.exp_ch); end
      bus.exp_rdy = 1; cyc(); bus.exp_rdy = 0;
   endtask

   task automatic test_arm_tick();
      bit seen = 0;
      ms_tick = 1; arm(1, 1); ms_tick = 0;
      checks++; if (bus.busy[1] !== 1'b1) begin errors++; $display("FAIL armtick_busy got %0b exp 1", bus.busy[1]); end
      repeat (3) begin cyc(); if (bus.exp_vld !== 1'b0) seen = 1; end
      checks++; if (seen) begin errors++; $display("FAIL armtick_early got event exp none"); end
      tick(); cyc();
      checks++; if (bus.exp_vld !== 1'b1 || bus.exp_ch !== 2'd1) begin
         errors++; $display("FAIL armtick_exp got vld=%0b ch=%0d exp vld=1 ch=1", bus.exp_vld, bus.exp_ch); end
      bus.exp_rdy = 1; cyc(); bus.exp_rdy = 0;
   endtask

   task automatic test_presented();
      arm(3, 0); cyc();
      checks++; if (bus.exp_vld !== 1'b1 || bus.exp_ch !== 2'd3) begin
         errors++; $display("FAIL pres_vld got vld=%0b ch=%0d exp vld=1 ch=3", bus.exp_vld, bus.exp_ch); end
      bus.arm_vld = 1; bus.arm_ch = 2'd2; #1;
      checks++; if (bus.arm_rdy !== 1'b1) begin errors++; $display("FAIL pres_rdy_other got %0b exp 1", bus.arm_rdy); end
      bus.arm_ch = 2'd3; bus.arm_ms = 16'd7; bus.cancel = 1; bus.cancel_ch = 2'd3; #1;
      checks++; if (bus.arm_rdy !== 1'b0) begin errors++; $display("FAIL pres_rdy got %0b exp 0", bus.arm_rdy); end
      cyc(); bus.arm_vld = 0; bus.cancel = 0;
      checks++; if (bus.exp_vld !== 1'b1 || bus.exp_ch !== 2'd3) begin
         errors++; $display("FAIL pres_hold got vld=%0b ch=%0d exp vld=1 ch=3", bus.exp_vld, bus.exp_ch); end
      repeat (3) cyc();
      bus.exp_rdy = 1; cyc(); bus.exp_rdy = 0;
      checks++; if (bus.exp_vld !== 1'b0 || bus.busy !== '0) begin
         errors++; $display("FAIL pres_deliver got vld=%0b busy=%b exp vld=0 busy=0", bus.exp_vld, bus.busy); end
      arm(3, 0); cyc(); cyc(); #3;
      rst = 0; #1;
      checks++; if (bus.exp_vld !== 1'b0 || bus.busy !== '0) begin
         errors++; $display("FAIL pres_rst got vld=%0b busy=%b exp vld=0 busy=0", bus.exp_vld, bus.busy); end
      cyc(); rst = 1; cyc();
   endtask

   task automatic model_step();
      int  ns [NCH];
      int  nr [NCH];
      bit  ok [NCH];
      bit  arm_ok, hs, pres, a, c;
      int  cand;
      arm_ok = bus.arm_vld && !(m_vld && m_ch == int'(bus.arm_ch));
      hs     = m_vld && bus.exp_rdy;
      for (int i = 0; i < NCH; i++) begin
         pres = m_vld && (m_ch == i);
         a    = arm_ok && (int'(bus.arm_ch) == i);
         c    = bus.cancel && (int'(bus.cancel_ch) == i) && !pres;
         ns[i] = m_st[i]; nr[i] = m_rem[i];
         if (a) begin
            ns[i] = (bus.arm_ms > 0) ? 1 : 2; nr[i] = int'(bus.arm_ms);
         end else if (hs && pres) ns[i] = 0;
         else if (c) begin ns[i] = 0; nr[i] = 0; end
         else if (m_st[i] == 1 && ms_tick) begin
            nr[i] = m_rem[i] - 1;
            if (nr[i] == 0) ns[i] = 2;
         end
         ok[i] = (m_st[i] == 2) && !a && !c;
      end
      if (hs) m_vld = 0;
      else if (!m_vld) begin
         for (int j = 1; j <= NCH; j++) begin
            cand = (m_rr + j) % NCH;
            if (ok[cand]) begin m_vld = 1; m_ch = cand; m_rr = cand; break; end
         end
      end
      m_st = ns; m_rem = nr;
   endtask

   task automatic test_random();
      logic [NCH-1:0] eb;
      bit             er;
      do_reset();
      for (int i = 0; i < NCH; i++) begin m_st[i] = 0; m_rem[i] = 0; end
      m_vld = 0; m_ch = 0; m_rr = NCH - 1;
      for (int n = 0; n < 400; n++) begin
         ms_tick       = ($urandom_range(0, 3) == 0);
         bus.arm_vld   = ($urandom_range(0, 3) == 0);
         bus.arm_ch    = CH_W'($urandom_range(0, NCH - 1));
         bus.arm_ms    = ($urandom_range(0, 15) == 0) ? 16'hFFFF : MS_W'($urandom_range(0, 4));
         bus.cancel    = ($urandom_range(0, 7) == 0);
         bus.cancel_ch = CH_W'($urandom_range(0, NCH - 1));
         bus.exp_rdy   = ($urandom_range(0, 1) == 1);
         #1;
         er = !(m_vld && m_ch == int'(bus.arm_ch));
         checks++; if (bus.arm_rdy !== er) begin errors++; $display("FAIL rnd_arm_rdy cyc %0d got %0b exp %0b", n, bus.arm_rdy, er); end
         model_step();
         cyc();
         for (int i = 0; i < NCH; i++) eb[i] = (m_st[i] != 0);
         checks++; if (bus.exp_vld !== m_vld || (m_vld && bus.exp_ch !== CH_W'(m_ch))) begin
            errors++; $display("FAIL rnd_exp cyc %0d got vld=%0b ch=%0d exp vld=%0b ch=%0d", n, bus.exp_vld, bus.exp_ch, m_vld, m_ch); end
         checks++; if (bus.busy !== eb) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", n, bus.busy, eb); end
      end
      idle_inputs();
   endtask

`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
   task automatic test_periodic();
      bit seen = 0;
      do_reset();
      bus.exp_rdy = 1; bus.arm_per = 1; arm(0, 4); bus.arm_per = 0;
      for (int p = 0; p < 5; p++) begin
         for (int t = 0; t < 4; t++) begin repeat (9) cyc(); tick(); end
         checks++; if (bus.exp_vld !== 1'b0) begin errors++; $display("FAIL per_early p %0d got 1 exp 0", p); end
         cyc();
         checks++; if (bus.exp_vld !== 1'b1 || bus.exp_ch !== 2'd0) begin
            errors++; $display("FAIL per_event p %0d got vld=%0b ch=%0d exp vld=1 ch=0", p, bus.exp_vld, bus.exp_ch); end
      end
      cyc();
      checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL per_reload got %0b exp 1", bus.busy[0]); end
      bus.cancel = 1; bus.cancel_ch = 2'd0; cyc(); bus.cancel = 0;
      for (int t = 0; t < 8; t++) begin
         repeat (4) cyc(); tick();
         if (bus.exp_vld !== 1'b0 || bus.busy !== '0) seen = 1;
      end
      checks++; if (seen) begin errors++; $display("FAIL per_cancel got activity exp none"); end
      bus.exp_rdy = 0;
   endtask
`endif

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_basic();
      test_back_to_back();
      test_cancel();
      test_arm_tick();
      test_presented();
      test_random();
`ifdef MS_TIMER_SCHED_AUTO_RELOAD_EN
      test_periodic();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
